// File: rtl/logic_unit_acc.sv
// ----------------------------------------------------------------------------
// logic_unit_acc
//
// Registered N-bit bitwise logic unit (AND / OR / XOR / NOR) with valid/ready
// handshakes on both sides. A beat can also open an accumulate burst. Each
// later beat of the burst is OR-folded into one result word. The burst closes
// on 'last' or when MAX_BEATS beats have been folded.
//
// Optional feature macro: LOGIC_UNIT_FLAGS_EN
//   When it is defined, the registered zero and parity flags of the result are
//   added as output ports.
//
// Parameters:
//   WIDTH      operand / result width in bits (>= 1)
//   MAX_BEATS  maximum beats per accumulate burst (>= 2)
//   CNT_W      derived width of the beat count
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   unit can accept a beat
//   op         00 AND, 01 OR, 10 XOR, 11 NOR
//   acc        beat opens an accumulate burst (looked at in IDLE only)
//   last       beat closes the burst
//   in1, in2   operands
//   out_valid  result held in the output register
//   out_ready  consumer accepts the result
//   out1       result word
//   nbeats     number of beats folded into out1
//   ovf        burst was closed by MAX_BEATS rather than by last
//   zero       result == 0 (LOGIC_UNIT_FLAGS_EN only)
//   parity     XOR of all result bits (LOGIC_UNIT_FLAGS_EN only)
// ----------------------------------------------------------------------------
module logic_unit_acc #(
    parameter int WIDTH      = 32,
    parameter int MAX_BEATS  = 8,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             acc,
    input  logic             last,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [CNT_W-1:0] nbeats,
    output logic             ovf
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic [WIDTH-1:0]   beat;
    logic [CNT_W-1:0]   cnt_inc;
    logic               at_limit;

    logic               load_out;
    logic [WIDTH-1:0]   load_val;
    logic [CNT_W-1:0]   load_cnt;
    logic               load_ovf;
    logic               acc_load;
    logic [WIDTH-1:0]   acc_val;
    logic [CNT_W-1:0]   cnt_val;

    // The input side is ready whenever the output register is empty or is
    // being drained this cycle. This never depends on the beat's contents.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign at_limit = (cnt_inc == CNT_W'(MAX_BEATS));

    // Per-beat bitwise result for the selected operation.
    always_comb begin
        beat = '0;
        unique case (op)
            2'b00:   beat = in1 & in2;
            2'b01:   beat = in1 | in2;
            2'b10:   beat = in1 ^ in2;
            default: beat = ~(in1 | in2);
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A burst closes on last or when the beat limit is reached.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (accept && acc && !last)        state_next = ACCUM;
            ACCUM: if (accept && (last || at_limit))  state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // Datapath control. Decides whether this cycle loads the output register
    // and what the accumulator and beat counter become. When a burst closes,
    // the accumulator and counter are cleared so the next burst starts from zero.
    always_comb begin
        load_out = 1'b0;
        load_val = beat;
        load_cnt = CNT_W'(1);
        load_ovf = 1'b0;
        acc_load = 1'b0;
        acc_val  = acc_reg;
        cnt_val  = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (acc && !last) begin
                        acc_load = 1'b1;
                        acc_val  = beat;
                        cnt_val  = CNT_W'(1);
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (last || at_limit) begin
                        load_out = 1'b1;
                        load_val = acc_reg | beat;
                        load_cnt = cnt_inc;
                        load_ovf = !last;
                        acc_load = 1'b1;
                        acc_val  = '0;
                        cnt_val  = '0;
                    end else begin
                        acc_load = 1'b1;
                        acc_val  = acc_reg | beat;
                        cnt_val  = cnt_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    // Burst accumulator and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt     <= '0;
        end else if (acc_load) begin
            acc_reg <= acc_val;
            cnt     <= cnt_val;
        end
    end

    // Output register. A load only happens when the register is empty or is
    // being drained, so the held data stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out1      <= '0;
            nbeats    <= '0;
            ovf       <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out1      <= load_val;
            nbeats    <= load_cnt;
            ovf       <= load_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    // Result flags are registered together with out1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero   <= 1'b0;
            parity <= 1'b0;
        end else if (load_out) begin
            zero   <= (load_val == '0);
            parity <= ^load_val;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_acc.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_acc
//
// Testbench for logic_unit_acc with WIDTH=8 and MAX_BEATS=4. Table-driven beats
// push their expected results into a scoreboard queue. A monitor pops one entry
// per output transfer and compares it. Hand-written sequences cover output
// stall and a reset asserted in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_logic_unit_acc;

    localparam int WIDTH     = 8;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int NVEC      = 21;

    typedef struct {
        logic [1:0]       op;
        logic             acc;
        logic             last;
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic             has_out;
        logic [WIDTH-1:0] exp_out1;
        logic [CNT_W-1:0] exp_nbeats;
        logic             exp_ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] out1;
        logic [CNT_W-1:0] nbeats;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             acc;
    logic             last;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out1;
    logic [CNT_W-1:0] nbeats;
    logic             ovf;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             zero;
    logic             parity;
`endif

    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[NVEC];
    vec_t hv;

    logic_unit_acc #(
        .WIDTH     (WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc       (acc),
        .last      (last),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .nbeats    (nbeats),
        .ovf       (ovf)
`ifdef LOGIC_UNIT_FLAGS_EN
        ,
        .zero      (zero),
        .parity    (parity)
`endif
    );

    // Free-running clock. Period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison. Prints a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one beat, waits (bounded) until it is accepted and records its
    // expected result if it closes a result. Returns one rising edge + #1 later.
    task automatic applyStimulus(input vec_t v);
        bit   accepted;
        exp_t e;
        in_valid = 1'b1;
        op       = v.op;
        acc      = v.acc;
        last     = v.last;
        in1      = v.in1;
        in2      = v.in2;
        accepted = 1'b0;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
        end
        if (!accepted) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
        end else if (v.has_out) begin
            e.out1   = v.exp_out1;
            e.nbeats = v.exp_nbeats;
            e.ovf    = v.exp_ovf;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Output monitor: one scoreboard entry per output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_output: got out1=%0h nbeats=%0d, expected none",
                         out1, nbeats);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("out1",   32'(out1),   32'(mon_e.out1));
                checkOutput("nbeats", 32'(nbeats), 32'(mon_e.nbeats));
                checkOutput("ovf",    32'(ovf),    32'(mon_e.ovf));
`ifdef LOGIC_UNIT_FLAGS_EN
                checkOutput("zero",   32'(zero),   32'(mon_e.out1 == '0));
                checkOutput("parity", 32'(parity), 32'(^mon_e.out1));
`endif
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        acc       = 1'b0;
        last      = 1'b0;
        in1       = '0;
        in2       = '0;

        //            op     acc   last  in1    in2    out  exp    nb    ovf
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h30, 3'd1, 1'b0};
        vecs[1]  = '{2'b01, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hFC, 3'd1, 1'b0};
        vecs[2]  = '{2'b10, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'hCC, 3'd1, 1'b0};
        vecs[3]  = '{2'b11, 1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 8'h03, 3'd1, 1'b0};
        // three-beat OR burst closed by last
        vecs[4]  = '{2'b01, 1'b1, 1'b0, 8'h01, 8'h02, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 1'b1, 8'h00, 8'h80, 1'b1, 8'h87, 3'd3, 1'b0};
        // burst closed by the beat limit, acc ignored mid-burst; fifth beat is fresh
        vecs[7]  = '{2'b00, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 1'b0, 8'h02, 8'h02, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[9]  = '{2'b00, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[10] = '{2'b00, 1'b0, 1'b0, 8'h08, 8'h08, 1'b1, 8'h0F, 3'd4, 1'b1};
        vecs[11] = '{2'b00, 1'b0, 1'b0, 8'h10, 8'h10, 1'b1, 8'h10, 3'd1, 1'b0};
        // mixed ops inside a burst: XOR then AND, folded with OR
        vecs[12] = '{2'b10, 1'b1, 1'b0, 8'hFF, 8'h0F, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[13] = '{2'b00, 1'b0, 1'b1, 8'h0C, 8'h0A, 1'b1, 8'hF8, 3'd2, 1'b0};
        // last arriving exactly on the limit beat: not an overflow
        vecs[14] = '{2'b01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[15] = '{2'b01, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[16] = '{2'b01, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[17] = '{2'b01, 1'b0, 1'b1, 8'h08, 8'h00, 1'b1, 8'h0F, 3'd4, 1'b0};
        // acc together with last in IDLE is a single beat
        vecs[18] = '{2'b10, 1'b1, 1'b1, 8'hAA, 8'h55, 1'b1, 8'hFF, 3'd1, 1'b0};
        // zero and odd-parity results
        vecs[19] = '{2'b00, 1'b0, 1'b0, 8'hF0, 8'h0F, 1'b1, 8'h00, 3'd1, 1'b0};
        vecs[20] = '{2'b01, 1'b0, 1'b0, 8'h03, 8'h04, 1'b1, 8'h07, 3'd1, 1'b0};

        // Values while reset is held
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out1",      32'(out1),      32'd0);
        checkOutput("rst_nbeats",    32'(nbeats),    32'd0);
        checkOutput("rst_ovf",       32'(ovf),       32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
        end
        repeat (2) @(posedge clk);
        #1;

        // Output stall: a result held for three cycles back-pressures the input
        out_ready = 1'b0;
        hv = '{2'b01, 1'b0, 1'b0, 8'h11, 8'h22, 1'b1, 8'h33, 3'd1, 1'b0};
        applyStimulus(hv);
        in_valid = 1'b1;
        op       = 2'b01;
        acc      = 1'b0;
        last     = 1'b0;
        in1      = 8'h44;
        in2      = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
            checkOutput("stall_out1",      32'(out1),      32'h33);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        sb.push_back('{8'h44, 3'd1, 1'b0});
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a two-beat partial burst
        hv = '{2'b01, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        applyStimulus(hv);
        hv = '{2'b01, 1'b0, 1'b0, 8'h0A, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
        applyStimulus(hv);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out1",      32'(out1),      32'd0);
        checkOutput("midrst_nbeats",    32'(nbeats),    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hv = '{2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 3'd1, 1'b0};
        applyStimulus(hv);

        // Drain the scoreboard within a bounded number of cycles
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
